// File: rtl/tx_sequencer_if.sv
// Upstream byte stream into the TX sequencer: valid/ready handshake, one byte per transfer.
interface tx_sequencer_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_data, output byte_valid, input byte_ready);
    modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/tx_sequencer.sv
// Packet sequencer for an FSK transmitter: oscillator warmup, 0x55 preamble,
// LSB-first payload from a one-byte holding register, then a modulator tail.
module tx_sequencer #(
    parameter int SAMPLES_PER_BIT = 4,
    parameter int WARMUP_CYCLES   = 16,
    parameter int TAIL_CYCLES     = 8
) (
    input  logic           top_clk,
    input  logic           top_rst,
    input  logic           start,
    input  logic [7:0]     pkt_len,
    tx_sequencer_if.slave  byte_if,
    output logic           osc_en,
    output logic           fsk_en,
    output logic           fsk_bit,
    output logic           bit_strobe,
    output logic           busy,
    output logic           done,
    output logic           underrun
);
    localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYCLES - 1);
    localparam logic [7:0] TAIL_LAST = 8'(TAIL_CYCLES - 1);
    localparam logic [7:0] SPB_LAST  = 8'(SAMPLES_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, WARMUP, PREAMBLE, PAYLOAD, TAIL} state_t;
    state_t state;

    logic [7:0] cyc_cnt, len, fetch_cnt, sent_cnt, shreg, hold_data;
    logic [2:0] bit_cnt;
    logic       hold_full;
    logic       take, bit_end, byte_end;

    assign byte_if.byte_ready = (state == WARMUP || state == PREAMBLE || state == PAYLOAD) &&
                                !hold_full && (fetch_cnt < len);
    assign take     = byte_if.byte_valid && byte_if.byte_ready;
    assign bit_end  = (cyc_cnt == SPB_LAST);
    assign byte_end = bit_end && (bit_cnt == 3'd7);
    assign busy     = (state != IDLE);

    always_ff @(posedge top_clk) begin
        if (!top_rst) begin
            state      <= IDLE;
            osc_en     <= 1'b0;
            fsk_en     <= 1'b0;
            fsk_bit    <= 1'b0;
            bit_strobe <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
            cyc_cnt    <= '0;
            len        <= '0;
            fetch_cnt  <= '0;
            sent_cnt   <= '0;
            shreg      <= '0;
            hold_data  <= '0;
            bit_cnt    <= '0;
            hold_full  <= 1'b0;
        end else begin
            bit_strobe <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
            case (state)
                IDLE: begin
                    // done is still high on the first IDLE cycle; a start there is ignored
                    if (start && !done) begin
                        state     <= WARMUP;
                        len       <= pkt_len;
                        osc_en    <= 1'b1;
                        cyc_cnt   <= '0;
                        fetch_cnt <= '0;
                        sent_cnt  <= '0;
                        hold_full <= 1'b0;
                    end
                end
                WARMUP: begin
                    if (cyc_cnt == WARM_LAST) begin
                        state      <= PREAMBLE;
                        cyc_cnt    <= '0;
                        fsk_en     <= 1'b1;
                        shreg      <= 8'h55;
                        fsk_bit    <= 1'b1;
                        bit_strobe <= 1'b1;
                        bit_cnt    <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                PREAMBLE, PAYLOAD: begin
                    cyc_cnt <= bit_end ? 8'd0 : cyc_cnt + 8'd1;
                    if (bit_end) begin
                        if (!byte_end) begin
                            bit_cnt    <= bit_cnt + 3'd1;
                            shreg      <= shreg >> 1;
                            fsk_bit    <= shreg[1];
                            bit_strobe <= 1'b1;
                        end else if (sent_cnt == len) begin
                            // all payload sent (or none requested): fsk_bit keeps last symbol
                            state <= TAIL;
                        end else if (hold_full) begin
                            state      <= PAYLOAD;
                            shreg      <= hold_data;
                            fsk_bit    <= hold_data[0];
                            bit_strobe <= 1'b1;
                            hold_full  <= 1'b0;
                            sent_cnt   <= sent_cnt + 8'd1;
                            bit_cnt    <= '0;
                        end else begin
                            state    <= IDLE;
                            underrun <= 1'b1;
                            osc_en   <= 1'b0;
                            fsk_en   <= 1'b0;
                            fsk_bit  <= 1'b0;
                        end
                    end
                end
                TAIL: begin
                    if (cyc_cnt == TAIL_LAST) begin
                        state   <= IDLE;
                        done    <= 1'b1;
                        osc_en  <= 1'b0;
                        fsk_en  <= 1'b0;
                        fsk_bit <= 1'b0;
                        cyc_cnt <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
            // take only happens with the register empty, so it never races a byte-boundary drain
            if (take) begin
                hold_full <= 1'b1;
                hold_data <= byte_if.byte_data;
                fetch_cnt <= fetch_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_tx_sequencer.sv
// Randomized directed bench for tx_sequencer: per-cycle outputs compared against
// a timeline derived from warmup/preamble/payload/tail durations.
module tb_tx_sequencer;
    localparam int SPB  = 4;
    localparam int WU   = 16;
    localparam int TL   = 8;
    localparam int PAY0 = WU + 1 + 8 * SPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pkt_len = 8'd0;
    logic       osc_en, fsk_en, fsk_bit, bit_strobe, busy, done, underrun;
    int         checks = 0;
    int         failures = 0;

    tx_sequencer_if bif();

    tx_sequencer #(.SAMPLES_PER_BIT(SPB), .WARMUP_CYCLES(WU), .TAIL_CYCLES(TL)) dut (
        .top_clk    (clk),
        .top_rst    (rst_n),
        .start      (start),
        .pkt_len    (pkt_len),
        .byte_if    (bif),
        .osc_en     (osc_en),
        .fsk_en     (fsk_en),
        .fsk_bit    (fsk_bit),
        .bit_strobe (bit_strobe),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int t, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
        end
    endtask

    // kind: 0 = normal done, 1 = underrun after `offer` bytes, 2 = reset pulled at rst_t
    task automatic run_pkt(input int len, input int vpct, input int offer_in, input int rst_t,
                           input bit poke, input int first);
        logic [7:0] pay[$];
        bit         bits[$];
        int         offer, end_t, kind, last, idx, xfers, rdy_seen, b;
        logic       pv, pr, v;
        logic       e_osc, e_fsk, e_bit, e_stb, e_busy, e_done, e_und;
        idx = 0; xfers = 0; rdy_seen = 0;
        for (int i = 0; i < len; i++)
            pay.push_back((i == 0 && first >= 0) ? 8'(first) : 8'($urandom));
        for (int i = 0; i < 8; i++) bits.push_back(i % 2 == 0);
        foreach (pay[i]) for (int j = 0; j < 8; j++) bits.push_back(pay[i][j]);
        offer = (offer_in < len) ? offer_in : len;
        if (rst_t > 0) begin
            end_t = rst_t + 1; kind = 2; last = end_t;
        end else if (offer < len) begin
            end_t = PAY0 + 8 * SPB * offer; kind = 1; last = end_t + 2;
        end else begin
            end_t = PAY0 + 8 * SPB * len + TL; kind = 0; last = end_t + 2;
        end

        pkt_len = 8'(len);
        start = 1'b1;
        v = (offer > 0) && ($urandom_range(0, 99) < vpct);
        bif.byte_valid = v;
        bif.byte_data  = v ? pay[0] : 8'($urandom);
        pv = v; pr = 1'b0;

        for (int t = 1; t <= last; t++) begin
            @(posedge clk); #1;
            if (pv && pr) begin xfers++; idx++; end
            start = 1'b0;
            pkt_len = 8'($urandom);
            {e_osc, e_fsk, e_bit, e_stb, e_busy, e_done, e_und} = '0;
            if (t < end_t) begin
                e_osc = 1'b1; e_busy = 1'b1;
                if (t >= WU + 1) begin
                    e_fsk = 1'b1;
                    if (t < PAY0 + 8 * SPB * len) begin
                        b = (t - WU - 1) / SPB;
                        e_bit = bits[b];
                        e_stb = ((t - WU - 1) % SPB) == 0;
                    end else begin
                        e_bit = bits[bits.size() - 1];
                    end
                end
            end else begin
                e_done = (kind == 0 && t == end_t);
                e_und  = (kind == 1 && t == end_t);
            end
            check("outputs", t, {1'b0, osc_en, fsk_en, fsk_bit, bit_strobe, busy, done, underrun},
                                {1'b0, e_osc, e_fsk, e_bit, e_stb, e_busy, e_done, e_und});
            if (bif.byte_ready) rdy_seen++;
            pr = bif.byte_ready;
            v = (idx < offer) && ($urandom_range(0, 99) < vpct);
            bif.byte_valid = v;
            bif.byte_data  = v ? pay[idx] : 8'($urandom);
            pv = v;
            if (poke && (t == PAY0 + 20 || (kind == 0 && t == end_t))) start = 1'b1;
            if (kind == 2 && t == rst_t) rst_n = 1'b0;
            if (kind == 2 && t == end_t) rst_n = 1'b1;
        end
        start = 1'b0;
        bif.byte_valid = 1'b0;
        if (kind != 2) check("transfers", 0, 8'(xfers), 8'(offer));
        if (len == 0) check("ready_never", 0, 8'(rdy_seen), 8'd0);
    endtask

    initial begin
        bif.byte_valid = 1'b0;
        bif.byte_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 0, {osc_en, fsk_en, fsk_bit, bit_strobe, busy, done, underrun, bif.byte_ready}, 8'd0);
        rst_n = 1'b1;

        run_pkt(1, 100, 1, 0, 1'b0, 8'hA5);   // reference timing, byte offered up front
        run_pkt(0, 50, 0, 0, 1'b0, -1);       // preamble straight into tail
        run_pkt(3, 100, 1, 0, 1'b0, -1);      // underrun at second byte boundary
        run_pkt(2, 60, 2, 0, 1'b1, -1);       // start poked in payload and on done cycle
        run_pkt(2, 60, 2, 60, 1'b0, -1);      // reset pulse mid-payload
        run_pkt(1, 100, 1, 0, 1'b0, 8'hA5);   // start on first edge after reset release
        run_pkt(16, 50, 16, 0, 1'b0, -1);     // random valid toggling, long packet
        for (int n = 0; n < 3; n++) run_pkt($urandom_range(1, 5), 40, 16, 0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
